// File: rtl/ysyx_25050141_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight and hands
// {pc, instr} to decode over a valid/ready handshake, squashing wrong-path fetches.
module ysyx_25050141_ifu #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = 32'h8000_0000
) (
  input  logic                            clk,
  input  logic                            rst,
  // instruction memory request channel
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [PC_WIDTH-1:0]             imem_req_addr,
  // instruction memory response channel
  input  logic                            imem_resp_valid,
  input  logic [INSTR_WIDTH-1:0]          imem_resp_data,
  input  logic                            imem_resp_err,
  // redirect from branch/jump/trap resolution
  input  logic                            redirect_valid,
  input  logic [PC_WIDTH-1:0]             redirect_pc,
  // decode channel
  output logic                            IF_to_DE_valid,
  input  logic                            DE_ready,
  output logic [PC_WIDTH+INSTR_WIDTH-1:0] IF_to_DE_bus,
  output logic                            if_fault,
  // debug view of the fetch FSM
  output logic [1:0]                      dbg_state
);

  // Handshake rule for every channel here: a transfer happens on a rising edge
  // where valid and ready are both 1; valid never depends on the same-cycle ready.
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

  logic [1:0]             state;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   fault_q;
  logic                   discard;

  logic [PC_WIDTH-1:0]    redirect_target;
  logic                   de_fire;

  assign redirect_target = redirect_pc & ~PC_WIDTH'(3);

  // Reset gates the decodes so nothing is offered while rst is low.
  assign imem_req_valid = rst && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign IF_to_DE_valid = rst && (state == S_OUT) && !redirect_valid;
  assign IF_to_DE_bus   = {pc, instr_q};
  assign if_fault       = fault_q && IF_to_DE_valid;
  assign dbg_state      = state;

  assign de_fire = IF_to_DE_valid && DE_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_target;
      end
      case (state)
        S_REQ: begin
          // A request accepted alongside a redirect is for the old PC: drop its data.
          if (imem_req_ready) begin
            state   <= S_WAIT;
            discard <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (discard || redirect_valid) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              instr_q <= imem_resp_data;
              fault_q <= imem_resp_err;
              state   <= S_OUT;
            end
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            state <= S_REQ;
          end else if (de_fire) begin
            pc    <= pc + PC_WIDTH'(4);
            state <= S_REQ;
          end
        end
        default: begin
          state   <= S_REQ;
          discard <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25050141_ifu.sv
// Directed bench for ysyx_25050141_ifu: per-cycle vector table with hand-computed
// outputs, then handshake-driven fetches with a varying-latency memory.
module tb_ysyx_25050141_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] I0     = 32'h0000_0093;
  localparam logic [31:0] I1     = 32'h0010_0113;
  localparam logic [31:0] D2     = 32'h0020_0193;
  localparam logic [31:0] D3     = 32'h0031_8213;
  localparam logic [31:0] D4     = 32'h0042_0293;
  localparam logic [31:0] D5     = 32'h0052_8313;
  localparam logic [31:0] D6     = 32'h0063_0393;
  localparam logic [31:0] D7     = 32'h0073_8413;
  localparam logic [31:0] D8     = 32'h0084_0493;
  localparam logic [31:0] DKEY   = 32'h5A5A_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IF_to_DE_valid;
  logic        DE_ready;
  logic [63:0] IF_to_DE_bus;
  logic        if_fault;
  logic [1:0]  dbg_state;

  ysyx_25050141_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .IF_to_DE_valid  (IF_to_DE_valid),
    .DE_ready        (DE_ready),
    .IF_to_DE_bus    (IF_to_DE_bus),
    .if_fault        (if_fault),
    .dbg_state       (dbg_state)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        redv;
    logic [31:0] redpc;
    logic        de;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_flt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic v(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                   input logic re, input logic redv, input logic [31:0] redpc, input logic de,
                   input logic e_rqv, input logic [31:0] e_addr, input logic e_dv,
                   input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_flt);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.rv = rv; t.rd = rd; t.re = re;
    t.redv = redv; t.redpc = redpc; t.de = de;
    t.e_rqv = e_rqv; t.e_addr = e_addr; t.e_dv = e_dv;
    t.e_pc = e_pc; t.e_instr = e_instr; t.e_flt = e_flt;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0; imem_resp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; DE_ready = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    vec_t t;
    t = vecs[i];
    @(negedge clk);
    rst = t.rst; imem_req_ready = t.rdy; imem_resp_valid = t.rv;
    imem_resp_data = t.rd; imem_resp_err = t.re;
    redirect_valid = t.redv; redirect_pc = t.redpc; DE_ready = t.de;
    #1;
    check($sformatf("v%0d_req_valid", i), 64'(imem_req_valid), 64'(t.e_rqv));
    check($sformatf("v%0d_req_addr", i), 64'(imem_req_addr), 64'(t.e_addr));
    check($sformatf("v%0d_de_valid", i), 64'(IF_to_DE_valid), 64'(t.e_dv));
    check($sformatf("v%0d_bus", i), IF_to_DE_bus, {t.e_pc, t.e_instr});
    check($sformatf("v%0d_fault", i), 64'(if_fault), 64'(t.e_flt));
  endtask

  // One fetch against a memory with random ready and 0..2 extra response cycles.
  task automatic run_fetch(input int k, input logic [31:0] exp_pc, input logic exp_err);
    logic        accepted;
    logic        seen;
    logic [31:0] addr;
    int          budget;
    int          lat;
    accepted = 1'b0; addr = 32'h0; budget = 0;
    while (!accepted && budget < 20) begin
      @(negedge clk);
      idle_inputs();
      imem_req_ready = 1'($urandom_range(0, 1));
      #1;
      if (imem_req_valid && imem_req_ready) begin
        accepted = 1'b1;
        addr = imem_req_addr;
      end
      budget++;
    end
    check($sformatf("f%0d_req_accepted", k), 64'(accepted), 64'(1));
    check($sformatf("f%0d_req_addr", k), 64'(addr), 64'(exp_pc));
    lat = $urandom_range(0, 2);
    repeat (lat) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check($sformatf("f%0d_no_req_in_wait", k), 64'(imem_req_valid), 64'(0));
    end
    @(negedge clk);
    idle_inputs();
    imem_resp_valid = 1'b1;
    imem_resp_data  = exp_pc ^ DKEY;
    imem_resp_err   = exp_err;
    seen = 1'b0; budget = 0;
    while (!seen && budget < 20) begin
      @(negedge clk);
      idle_inputs();
      DE_ready = 1'b1;
      #1;
      seen = IF_to_DE_valid;
      budget++;
    end
    check($sformatf("f%0d_de_valid_seen", k), 64'(seen), 64'(1));
    check($sformatf("f%0d_bus", k), IF_to_DE_bus, {exp_pc, exp_pc ^ DKEY});
    check($sformatf("f%0d_fault", k), 64'(if_fault), 64'(exp_err));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;

    // rst rdy rv rd re redv redpc de | rqv addr dv pc instr flt
    // reset release and zero-wait back-to-back fetches
    v(0,0,0,0,0,0,0,1,  0,RST_PC,0,RST_PC,NOP,0);
    v(1,1,0,0,0,0,0,0,  1,RST_PC,0,RST_PC,NOP,0);
    v(1,0,1,I0,0,0,0,0, 0,RST_PC,0,RST_PC,NOP,0);
    v(1,0,0,0,0,0,0,1,  0,RST_PC,1,RST_PC,I0,0);
    v(1,1,0,0,0,0,0,0,  1,RST_PC+4,0,RST_PC+4,I0,0);
    v(1,0,1,I1,0,0,0,0, 0,RST_PC+4,0,RST_PC+4,I0,0);
    v(1,0,0,0,0,0,0,1,  0,RST_PC+4,1,RST_PC+4,I1,0);
    // faulted fetch at +8, held 4 cycles by decode
    v(1,1,0,0,0,0,0,0,  1,RST_PC+8,0,RST_PC+8,I1,0);
    v(1,0,1,D2,1,0,0,0, 0,RST_PC+8,0,RST_PC+8,I1,0);
    v(1,0,0,0,0,0,0,0,  0,RST_PC+8,1,RST_PC+8,D2,1);
    v(1,0,0,0,0,0,0,0,  0,RST_PC+8,1,RST_PC+8,D2,1);
    v(1,0,0,0,0,0,0,0,  0,RST_PC+8,1,RST_PC+8,D2,1);
    v(1,0,0,0,0,0,0,0,  0,RST_PC+8,1,RST_PC+8,D2,1);
    v(1,0,0,0,0,0,0,1,  0,RST_PC+8,1,RST_PC+8,D2,1);
    v(1,0,0,0,0,0,0,0,  1,RST_PC+12,0,RST_PC+12,D2,0);
    v(1,1,0,0,0,0,0,0,  1,RST_PC+12,0,RST_PC+12,D2,0);
    v(1,0,1,D3,0,0,0,0, 0,RST_PC+12,0,RST_PC+12,D2,0);
    v(1,0,0,0,0,0,0,1,  0,RST_PC+12,1,RST_PC+12,D3,0);
    // redirect while waiting on a 3-cycle memory
    v(1,1,0,0,0,0,0,0,  1,RST_PC+16,0,RST_PC+16,D3,0);
    v(1,0,0,0,0,1,32'h8000_0102,0, 0,RST_PC+16,0,RST_PC+16,D3,0);
    v(1,0,0,0,0,0,0,0,  0,32'h8000_0100,0,32'h8000_0100,D3,0);
    v(1,0,1,32'hDEAD_BEEF,0,0,0,1, 0,32'h8000_0100,0,32'h8000_0100,D3,0);
    v(1,1,0,0,0,0,0,1,  1,32'h8000_0100,0,32'h8000_0100,D3,0);
    v(1,0,1,D4,0,0,0,0, 0,32'h8000_0100,0,32'h8000_0100,D3,0);
    v(1,0,0,0,0,0,0,1,  0,32'h8000_0100,1,32'h8000_0100,D4,0);
    // redirect in the same cycle the request is accepted
    v(1,1,0,0,0,1,32'h8000_0203,0, 1,32'h8000_0104,0,32'h8000_0104,D4,0);
    v(1,0,1,32'hBAD0_BAD0,0,0,0,1, 0,32'h8000_0200,0,32'h8000_0200,D4,0);
    v(1,1,0,0,0,0,0,0,  1,32'h8000_0200,0,32'h8000_0200,D4,0);
    v(1,0,1,D5,0,0,0,0, 0,32'h8000_0200,0,32'h8000_0200,D4,0);
    v(1,0,0,0,0,0,0,1,  0,32'h8000_0200,1,32'h8000_0200,D5,0);
    // redirect while presenting to decode, then redirect in an unaccepted request
    v(1,1,0,0,0,0,0,0,  1,32'h8000_0204,0,32'h8000_0204,D5,0);
    v(1,0,1,D6,0,0,0,0, 0,32'h8000_0204,0,32'h8000_0204,D5,0);
    v(1,0,0,0,0,1,32'h8000_0300,1, 0,32'h8000_0204,0,32'h8000_0204,D6,0);
    v(1,0,0,0,0,1,32'h8000_0401,0, 1,32'h8000_0300,0,32'h8000_0300,D6,0);
    v(1,1,0,0,0,0,0,0,  1,32'h8000_0400,0,32'h8000_0400,D6,0);
    v(1,0,1,D7,0,0,0,0, 0,32'h8000_0400,0,32'h8000_0400,D6,0);
    v(1,0,0,0,0,0,0,1,  0,32'h8000_0400,1,32'h8000_0400,D7,0);
    // PC wrap at the top of the address space
    v(1,0,0,0,0,1,32'hFFFF_FFFF,0, 1,32'h8000_0404,0,32'h8000_0404,D7,0);
    v(1,1,0,0,0,0,0,0,  1,32'hFFFF_FFFC,0,32'hFFFF_FFFC,D7,0);
    v(1,0,1,D8,0,0,0,0, 0,32'hFFFF_FFFC,0,32'hFFFF_FFFC,D7,0);
    v(1,0,0,0,0,0,0,1,  0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,D8,0);
    v(1,0,0,0,0,0,0,0,  1,32'h0000_0000,0,32'h0000_0000,D8,0);
    // reset while waiting; late response ignored
    v(1,1,0,0,0,0,0,0,  1,32'h0000_0000,0,32'h0000_0000,D8,0);
    v(0,0,0,0,0,0,0,1,  0,32'h0000_0000,0,32'h0000_0000,D8,0);
    v(0,0,1,32'hBADB_ADBA,0,0,0,1, 0,RST_PC,0,RST_PC,NOP,0);
    v(1,0,1,32'h1111_1111,0,0,0,1, 1,RST_PC,0,RST_PC,NOP,0);
    v(1,1,0,0,0,0,0,0,  1,RST_PC,0,RST_PC,NOP,0);
    v(1,0,1,I0,0,0,0,0, 0,RST_PC,0,RST_PC,NOP,0);
    v(1,0,0,0,0,0,0,1,  0,RST_PC,1,RST_PC,I0,0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(i);
    end

    for (int k = 0; k < 4; k++) begin
      run_fetch(k, RST_PC + 32'(4 * (k + 1)), (k == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
